// File: rtl/mix_col_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mix_col_engine : handshaked AES (Inv)MixColumns, COLS_PER_CYCLE per beat  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module mix_col_engine #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         inv,
  input  logic [0:127] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] mix_data,
  output logic         busy
);

  localparam int C_BEATS  = (COLS_PER_CYCLE > 0) ? 4 / COLS_PER_CYCLE : 1;
  localparam int C_BEAT_W = (C_BEATS > 1) ? $clog2(C_BEATS) : 1;
  localparam logic [C_BEAT_W-1:0] C_LAST_BEAT = C_BEAT_W'(C_BEATS - 1);

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
      $error("mix_col_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [C_BEAT_W-1:0]   beat_q, beat_d;
  logic [0:3][31:0]      work_q, work_d;
  logic [0:3][31:0]      w_work_mixed;
  logic                  inv_q, inv_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;

  logic [1:0]            w_idx  [COLS_PER_CYCLE];
  logic [31:0]           w_lane [COLS_PER_CYCLE];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // prod[j][k] = byte j times the k-th mode coefficient; row i uses coefficient (j-i) mod 4.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic mode);
    logic [7:0]  s, x2, x4, x8;
    logic [7:0]  prod [4][4];
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      s  = col[31-8*j -: 8];
      x2 = xtime(s);
      x4 = xtime(x2);
      x8 = xtime(x4);
      if (mode) begin
        prod[j][0] = x8 ^ x4 ^ x2;
        prod[j][1] = x8 ^ x2 ^ s;
        prod[j][2] = x8 ^ x4 ^ s;
        prod[j][3] = x8 ^ s;
      end else begin
        prod[j][0] = x2;
        prod[j][1] = x2 ^ s;
        prod[j][2] = s;
        prod[j][3] = s;
      end
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        r[31-8*i -: 8] = r[31-8*i -: 8] ^ prod[j][(j - i + 4) % 4];
      end
    end
    return r;
  endfunction

  generate
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
      assign w_idx[g]  = 2'(int'(beat_q) * COLS_PER_CYCLE + g);
      assign w_lane[g] = mix_col(work_q[w_idx[g]], inv_q);
    end
  endgenerate

  always_comb begin
    w_work_mixed = work_q;
    for (int i = 0; i < COLS_PER_CYCLE; i++) begin
      w_work_mixed[w_idx[i]] = w_lane[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    work_d      = work_q;
    inv_d       = inv_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        if (in_valid && in_ready_q) begin
          work_d     = data_in;
          inv_d      = inv;
          beat_d     = '0;
          state_d    = BUSY;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      BUSY: begin
        work_d = w_work_mixed;
        if (beat_q == C_LAST_BEAT) begin
          state_d     = DONE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      work_q      <= '0;
      inv_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      work_q      <= work_d;
      inv_q       <= inv_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign mix_data  = work_q;

endmodule
`default_nettype wire

// File: tb/tb_mix_col_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mix_col_engine : directed + random bench for mix_col_engine (CPC 1/2/4)|
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_mix_col_engine;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         inv = 1'b0;
  logic         out_ready = 1'b0;
  logic [0:127] data_in = '0;
  logic         in_valid_v  [3];
  logic         in_ready_v  [3];
  logic         out_valid_v [3];
  logic         busy_v      [3];
  logic [0:127] mix_v       [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      mix_col_engine #(.COLS_PER_CYCLE(1 << g)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_v[g]),
        .in_ready  (in_ready_v[g]),
        .inv       (inv),
        .data_in   (data_in),
        .out_valid (out_valid_v[g]),
        .out_ready (out_ready),
        .mix_data  (mix_v[g]),
        .busy      (busy_v[g])
      );
    end
  endgenerate

  // Reference: plain GF(2^8) shift-and-add multiply and a 4x4 circulant matrix product.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [0:127] ref_mix(input logic [0:127] st, input logic m);
    logic [7:0]   cf [4];
    logic [7:0]   acc;
    logic [0:127] o;
    if (m) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else   cf = '{8'h02, 8'h03, 8'h01, 8'h01};
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        acc = '0;
        for (int j = 0; j < 4; j++) acc = acc ^ gm(cf[(j - i + 4) % 4], st[32*c + 8*j +: 8]);
        o[32*c + 8*i +: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic logic [0:127] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [0:127] obs, input logic [0:127] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input int k);
    int g;
    g = 0;
    in_valid_v[k] = 1'b1;
    while (!in_ready_v[k] && g < 50) begin
      tick();
      g++;
    end
    chk("accept_timeout", 128'(g < 50), 128'(1));
    tick();
    in_valid_v[k] = 1'b0;
    chk("busy_after_accept", 128'(busy_v[k]), 128'(1));
    chk("in_ready_after_accept", 128'(in_ready_v[k]), 128'(0));
  endtask

  task automatic wait_out(input int k, output int lat);
    lat = 0;
    while (!out_valid_v[k] && lat < 50) begin
      tick();
      lat++;
    end
    chk("out_valid_timeout", 128'(lat < 50), 128'(1));
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic xact(input int k, input logic [0:127] d, input logic m, input bit toggle,
                      input int stall, output logic [0:127] res, output int lat);
    data_in = d;
    inv     = m;
    wait_accept(k);
    if (toggle) inv = ~m;
    wait_out(k, lat);
    repeat (stall) tick();
    res = mix_v[k];
    take();
  endtask

  logic [0:127] x, y, res, res2, snap;
  logic         m;
  int           lat;

  initial begin
    for (int k = 0; k < 3; k++) in_valid_v[k] = 1'b0;
    #2;
    chk("rst_in_ready", 128'(in_ready_v[0]), 128'(0));
    chk("rst_out_valid", 128'(out_valid_v[0]), 128'(0));
    chk("rst_busy", 128'(busy_v[0]), 128'(0));
    chk("rst_mix_data", mix_v[0], 128'(0));
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 128'(in_ready_v[0]), 128'(1));

    // T1: forward, known vector, latency 4
    x = {4{32'hdb135345}};
    xact(0, x, 1'b0, 1'b0, 0, res, lat);
    chk("t1_result", res, {4{32'h8e4da1bc}});
    chk("t1_model", res, ref_mix(x, 1'b0));
    chk("t1_latency", 128'(lat), 128'(4));
    chk("t1_out_valid_drop", 128'(out_valid_v[0]), 128'(0));
    chk("t1_in_ready_back", 128'(in_ready_v[0]), 128'(1));

    // T2: inverse, inv toggled while busy
    xact(0, {4{32'h8e4da1bc}}, 1'b1, 1'b1, 0, res, lat);
    chk("t2_result", res, {4{32'hdb135345}});

    // T3: mixed state on all three column rates
    x = 128'hf20a225c_01010101_c6c6c6c6_d4d4d4d5;
    for (int k = 0; k < 3; k++) begin
      xact(k, x, 1'b0, 1'b0, 0, res, lat);
      chk("t3_result", res, 128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6);
      chk("t3_latency", 128'(lat), 128'(4 >> k));
    end

    // T4: output stall with a pending new request
    x = rand128();
    y = rand128();
    data_in = x;
    inv     = 1'b0;
    wait_accept(0);
    wait_out(0, lat);
    snap    = mix_v[0];
    chk("t4_result", snap, ref_mix(x, 1'b0));
    data_in = y;
    inv     = 1'b1;
    in_valid_v[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_hold_data", mix_v[0], snap);
      chk("t4_hold_valid", 128'(out_valid_v[0]), 128'(1));
      chk("t4_hold_in_ready", 128'(in_ready_v[0]), 128'(0));
    end
    take();
    chk("t4_valid_drop", 128'(out_valid_v[0]), 128'(0));
    chk("t4_busy_idle", 128'(busy_v[0]), 128'(0));
    wait_accept(0);
    wait_out(0, lat);
    chk("t4_second_result", mix_v[0], ref_mix(y, 1'b1));
    take();

    // T5: async reset at beat 2
    data_in = rand128();
    inv     = 1'b0;
    wait_accept(0);
    tick();
    tick();
    chk("t5_busy_before", 128'(busy_v[0]), 128'(1));
    rst = 1'b1;
    #1;
    chk("t5_out_valid", 128'(out_valid_v[0]), 128'(0));
    chk("t5_busy", 128'(busy_v[0]), 128'(0));
    chk("t5_mix_cleared", mix_v[0], 128'(0));
    tick();
    rst = 1'b0;
    tick();
    x = rand128();
    xact(0, x, 1'b1, 1'b0, 0, res, lat);
    chk("t5_after_result", res, ref_mix(x, 1'b1));
    chk("t5_after_latency", 128'(lat), 128'(4));

    // T6: random back-to-back traffic with output stalls
    for (int n = 0; n < 1000; n++) begin
      x = rand128();
      m = 1'($urandom_range(0, 1));
      xact(0, x, m, 1'b0, int'($urandom_range(0, 3)), res, lat);
      chk("t6_result", res, ref_mix(x, m));
      if (n % 100 == 0) begin
        xact(0, res, ~m, 1'b0, 0, res2, lat);
        chk("t6_roundtrip", res2, x);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
